// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store per request, waits WAIT_CYCLES
// wait states, then completes the access with a one-cycle ready pulse.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        req,
    input  logic        wmem,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    wmem_q;
    logic [31:0]             addr_q;
    logic [31:0]             wdata_q;
    logic                    fault;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [31:0]             mem [0:(1 << DEPTH_LOG2)-1];

    // Anything above the word index must be zero for the access to hit the store.
    always_comb begin
        idx   = addr_q[DEPTH_LOG2+1:2];
        fault = (addr_q[1:0] != 2'b00) || ((addr_q >> (DEPTH_LOG2 + 2)) != '0);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            cnt     <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            wmem_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        wmem_q  <= wmem;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt     <= 4'(WAIT_CYCLES);
                        busy    <= 1'b1;
                        state   <= (WAIT_CYCLES == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= DONE;
                end
                DONE: begin
                    ready <= 1'b1;
                    err   <= fault;
                    rdata <= (fault || wmem_q) ? '0 : mem[idx];
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Storage is deliberately outside the reset domain so contents survive clrn.
    always_ff @(posedge clk) begin
        if (state == DONE && wmem_q && !fault) mem[idx] <= wdata_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (2 wait states / 1 KiB and
// 0 wait states / 64 B) driven with random and directed loads and stores.
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          rdy;
    } sb_t;

    logic        clk;
    logic        clrn;
    logic        req   [2];
    logic        wmem  [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ready [2];
    logic [31:0] rdata [2];
    logic        err   [2];
    logic        busy  [2];

    sb_t         q0[$];
    sb_t         q1[$];
    logic [31:0] m0 [256];
    logic [31:0] m1 [16];
    int          cyc;
    int          rdy_cnt [2];
    int          n_pass;
    int          n_fail;
    int          n_tot;

    dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .clrn(clrn), .req(req[0]), .wmem(wmem[0]), .addr(addr[0]),
        .wdata(wdata[0]), .ready(ready[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0])
    );

    dmem_responder #(.DEPTH_LOG2(4), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .clrn(clrn), .req(req[1]), .wmem(wmem[1]), .addr(addr[1]),
        .wdata(wdata[1]), .ready(ready[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int qsize(int d);
        return (d == 1) ? q1.size() : q0.size();
    endfunction

    // Reference model: word-addressed array, fault = misaligned or beyond the store size.
    task automatic push(int d, logic w, logic [31:0] a, logic [31:0] wd, int acc);
        sb_t e;
        int  dl;
        dl      = (d == 1) ? 4 : 8;
        e.acc   = acc;
        e.rdy   = acc + ((d == 1) ? 0 : 2) + 1;
        e.err   = (a[1:0] != 2'b00) || (a >= (32'd4 << dl));
        e.rdata = '0;
        if (!e.err) begin
            if (w) begin
                if (d == 1) m1[int'(a >> 2)] = wd;
                else        m0[int'(a >> 2)] = wd;
            end else begin
                e.rdata = (d == 1) ? m1[int'(a >> 2)] : m0[int'(a >> 2)];
            end
        end
        if (d == 1) q1.push_back(e);
        else        q0.push_back(e);
    endtask

    task automatic mon(int d);
        sb_t e;
        if (ready[d]) begin
            rdy_cnt[d]++;
            check($sformatf("busy_at_ready%0d", d), 32'(busy[d]), 32'd0);
            if (qsize(d) == 0) begin
                n_tot++;
                n_fail++;
                $display("FAIL spurious_ready%0d: got ready=1 expected no ready (cycle %0d)", d, cyc);
            end else begin
                e = (d == 1) ? q1.pop_front() : q0.pop_front();
                check($sformatf("rdata%0d", d), rdata[d], e.rdata);
                check($sformatf("err%0d", d), 32'(err[d]), 32'(e.err));
                check($sformatf("latency%0d", d), 32'(cyc), 32'(e.rdy));
            end
        end else if (qsize(d) > 0) begin
            e = (d == 1) ? q1[0] : q0[0];
            if (cyc >= e.acc && cyc < e.rdy)
                check($sformatf("busy%0d", d), 32'(busy[d]), 32'd1);
            else if (cyc == e.rdy)
                check($sformatf("missing_ready%0d", d), 32'(ready[d]), 32'd1);
        end
    endtask

    always @(negedge clk) begin
        if (clrn) begin
            mon(0);
            mon(1);
        end
    end

    task automatic drain(int d);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (qsize(d) == 0) return;
        end
        n_tot++;
        n_fail++;
        $display("FAIL drain%0d: got %0d outstanding expected 0", d, qsize(d));
        if (d == 1) q1.delete();
        else        q0.delete();
    endtask

    task automatic scramble(int d);
        wmem[d]  = 1'($urandom);
        addr[d]  = $urandom;
        wdata[d] = $urandom;
    endtask

    task automatic issue(int d, logic w, logic [31:0] a, logic [31:0] wd);
        @(negedge clk);
        req[d] = 1'b1; wmem[d] = w; addr[d] = a; wdata[d] = wd;
        @(posedge clk);
        #1;
        push(d, w, a, wd, cyc);
        req[d] = 1'b0;
        scramble(d);
        drain(d);
    endtask

    function automatic logic [31:0] rand_word(int d);
        return 32'($urandom_range(0, (d == 1) ? 15 : 255)) << 2;
    endfunction

    function automatic logic [31:0] rand_addr(int d);
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return rand_word(d) | 32'($urandom_range(1, 3));
        if (r == 1) return ((d == 1) ? 32'd64 : 32'd1024) + (32'($urandom_range(0, 4095)) << 2);
        if (r == 2) return $urandom | 32'h8000_0000;
        return rand_word(d);
    endfunction

    // req held high: each access is accepted on the edge right after the previous ready cycle.
    task automatic burst(int d, int n, bit st, logic [31:0] base);
        logic        cw;
        logic [31:0] ca;
        logic [31:0] cd;
        int          w;
        w  = (d == 1) ? 0 : 2;
        cw = st; ca = base; cd = $urandom;
        @(negedge clk);
        req[d] = 1'b1; wmem[d] = cw; addr[d] = ca; wdata[d] = cd;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            push(d, cw, ca, cd, cyc);
            cw = 1'b0;
            ca = (k + 1 < 2) ? base : rand_word(d);
            cd = $urandom;
            if (k == n - 1) begin
                req[d] = 1'b0;
                scramble(d);
            end else begin
                wmem[d] = cw; addr[d] = ca; wdata[d] = cd;
                repeat (w + 1) @(posedge clk);
            end
        end
        drain(d);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved;
        int          rc;
        n_pass = 0; n_fail = 0; n_tot = 0; cyc = 0;
        rdy_cnt[0] = 0; rdy_cnt[1] = 0;
        clrn = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; wmem[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
        end
        #1 clrn = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_ready%0d", d), 32'(ready[d]), 32'd0);
            check($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
            check($sformatf("rst_err%0d", d), 32'(err[d]), 32'd0);
            check($sformatf("rst_rdata%0d", d), rdata[d], 32'd0);
        end
        repeat (3) @(negedge clk);
        clrn = 1'b1;

        for (int i = 0; i < 256; i++) issue(0, 1'b1, 32'(i) << 2, $urandom);
        issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        issue(0, 1'b0, 32'h10, $urandom);
        issue(0, 1'b1, 32'h13, 32'h1234_5678);
        issue(0, 1'b0, 32'h10, $urandom);
        issue(0, 1'b0, 32'h400, $urandom);
        issue(0, 1'b1, 32'h3FC, $urandom);
        issue(0, 1'b0, 32'h3FC, $urandom);
        issue(0, 1'b1, 32'hFFFF_FFFC, $urandom);
        issue(0, 1'b0, 32'h0, $urandom);
        for (int i = 0; i < 40; i++) issue(0, 1'($urandom), rand_addr(0), $urandom);
        burst(0, 3, 1'b0, 32'h10);
        burst(0, 3, 1'b1, 32'h44);

        issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        issue(0, 1'b0, 32'h10, $urandom);
        saved = m0[8];
        @(negedge clk);
        req[0] = 1'b1; wmem[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        push(0, 1'b1, 32'h20, 32'hCAFE_F00D, cyc);
        req[0] = 1'b0;
        m0[8] = saved;
        @(posedge clk);
        #3 clrn = 1'b0;
        q0.delete(q0.size() - 1);
        #1;
        check("abort_ready", 32'(ready[0]), 32'd0);
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_err", 32'(err[0]), 32'd0);
        check("abort_rdata", rdata[0], 32'd0);
        rc = rdy_cnt[0];
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("abort_no_ready", 32'(rdy_cnt[0] - rc), 32'd0);
        issue(0, 1'b0, 32'h20, $urandom);

        for (int i = 0; i < 16; i++) issue(1, 1'b1, 32'(i) << 2, $urandom);
        for (int i = 0; i < 30; i++) issue(1, 1'($urandom), rand_addr(1), $urandom);
        issue(1, 1'b0, 32'h40, $urandom);
        burst(1, 4, 1'b1, 32'h8);
        burst(1, 3, 1'b1, 32'h3C);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
